reloj_nios2_qsys_0_mulx_seq: RTL and testbench
==============================================

# reloj_nios2_qsys_0_mulx_seq

Multiply sequencer that sits directly upstream of the Nios II 32-bit multiply cell. It accepts one multiply request at a time and returns one 32-bit result.
- For plain MUL it drives the operands straight through one cell pass.
- For MULXUU, MULXSU and MULXSS it issues four 16x16 partial-product passes through the cell, accumulates a 64-bit product and applies signed correction to return the upper 32 bits.

## Interface

Parameters:
- MUL_LATENCY, 1: number of register stages inside the cell. A result for operands present in cycle c is valid during cycle c+MUL_LATENCY. Legal range 1..3.

Ports:
- clk  in  1  single clock for the whole block.
- reset_n  in  1  reset, synchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_op  in  2  operation: 00 MUL, 01 MULXUU, 10 MULXSU (a signed, b unsigned), 11 MULXSS.
- req_a  in  32  operand a.
- req_b  in  32  operand b.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer accepts the result.
- rsp_data  out  32  result.
- mul_src1  out  32  operand 1 to the multiply cell.
- mul_src2  out  32  operand 2 to the multiply cell.
- mul_result  in  32  low 32 bits of mul_src1*mul_src2 from the cell, MUL_LATENCY cycles later.

## Operation

- States: IDLE, ISSUE, DRAIN, FIX, RESP.
- req_ready = (state==IDLE) && reset_n, combinational.
- Accept: req_valid && req_ready at a clock edge. On accept, latch a, b and op; clear the 64-bit accumulator; go to ISSUE. req_valid outside IDLE is ignored.
- ISSUE for MUL: 1 cycle. Drives mul_src1=a, mul_src2=b.
- ISSUE for MULX*: 4 cycles, issue counter k=0..3, one pass per cycle:
  - k=0 (LL): {16'h0,a[15:0]}, {16'h0,b[15:0]}, shift 0
  - k=1 (LH): {16'h0,a[15:0]}, {16'h0,b[31:16]}, shift 16
  - k=2 (HL): {16'h0,a[31:16]}, {16'h0,b[15:0]}, shift 16
  - k=3 (HH): {16'h0,a[31:16]}, {16'h0,b[31:16]}, shift 32
- mul_src1/mul_src2 are registered and are 0 in every cycle outside ISSUE.
- Capture tracking: a shift register MUL_LATENCY deep carries a valid bit and the pass index.
  - MULX*: when a tagged pass emerges, acc += zero_extend(mul_result) << shift, modulo 2^64.
  - MUL: the single pass result is latched directly as the response.
- DRAIN: entered after the last issue; remains until the tag pipe is empty.
- FIX (1 cycle, MULX* only): hi = acc[63:32], then, modulo 2^32:
  - MULXSU: hi -= (a[31] ? b : 0)
  - MULXSS: hi -= (a[31] ? b : 0) + (b[31] ? a : 0)
- MUL bypasses FIX.
- RESP: rsp_valid=1 and rsp_data stable until rsp_valid && rsp_ready. On that handshake go to IDLE, with rsp_valid=0 on the next cycle. A new request cannot be accepted in the same cycle as the handshake.
- Reset (reset_n=0 at an edge, in any state): state IDLE, tag pipe cleared, accumulator 0, rsp_valid 0, rsp_data 0, mul_src1/2 0. An in-flight operation is discarded and no response is produced.

## Timing

- Cycle numbering: accept edge ends cycle 0. Pass k operands are present in cycle k+1. The pass k result is accumulated at the end of cycle k+1+MUL_LATENCY.
- MUL: rsp_valid first high in cycle 2+MUL_LATENCY (cycle 3 at default).
- MULX*:
  - Last accumulate ends cycle 4+MUL_LATENCY.
  - FIX occupies cycle 5+MUL_LATENCY.
  - rsp_valid first high in cycle 6+MUL_LATENCY (cycle 7 at default).
- Throughput: one operation at a time. Next accept is no earlier than 1 cycle after the response handshake.
- Reset values: req_ready 0 while reset_n=0, then 1. rsp_valid 0. rsp_data 0x00000000. mul_src1/2 0x00000000.

## Test plan

- MUL a=0x00010003 b=0x00020005 -> rsp_data=0x000B000F, rsp_valid first in cycle 3. mul_src1/2 carry full operands in cycle 1 only.
- MULXUU a=0xFFFFFFFF b=0xFFFFFFFF -> 0xFFFFFFFE in cycle 7. Passes LL/LH/HL/HH appear in cycles 1-4 with 0x0000FFFF operands.
- MULXSS a=0xFFFFFFFF b=0x00000002 -> 0xFFFFFFFF. MULXSU a=0x80000000 b=0x80000000 -> 0xC0000000. MULXSS a=0x80000000 b=0x80000000 -> 0x40000000.
- Backpressure: hold rsp_ready=0 for 5 cycles after rsp_valid, with req_valid=1 throughout.
  - rsp_valid and rsp_data stay stable and req_ready stays 0.
  - After the handshake: rsp_valid=0 next cycle, then the pending request is accepted.
- Reset mid-op: reset_n=0 in cycle 3 of a MULXUU.
  - Next edge: rsp_valid=0, mul_src=0, req_ready=1 after release.
  - A following MULXUU 0x00010000*0x00010000 returns 0x00000001, uncorrupted.
- MUL_LATENCY=2 (cell model delayed accordingly): MULXUU 0x00010000*0x00010000 -> 0x00000001 in cycle 8. MUL 0x00000007*0x00000006 -> 0x0000002A in cycle 4.

Source files
------------

// File: rtl/reloj_nios2_qsys_0_mulx_seq.sv
// Multiply sequencer in front of the Nios II 32-bit multiply cell.
// MUL goes through the cell in one pass. MULXUU/MULXSU/MULXSS use four 16x16 passes
// into a 64-bit accumulator. A signed correction is then applied to the upper word.
module reloj_nios2_qsys_0_mulx_seq #(
  parameter int unsigned MUL_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic [31:0] mul_src1,
  output logic [31:0] mul_src2,
  input  logic [31:0] mul_result
);

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StDrain,
    StFix,
    StResp
  } state_e;

  localparam logic [1:0] OpMul    = 2'b00;
  localparam logic [1:0] OpMulxsu = 2'b10;
  localparam logic [1:0] OpMulxss = 2'b11;

  state_e      state_q, state_d;
  logic [1:0]  op_q, op_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [1:0]  k_q, k_d;
  logic [63:0] acc_q, acc_d;
  logic [31:0] rsp_data_q, rsp_data_d;
  logic [31:0] src1_q, src1_d;
  logic [31:0] src2_q, src2_d;

  // Tag pipe mirrors the cell's register stages: valid bit plus pass index.
  logic [MUL_LATENCY-1:0]       tag_vld_q, tag_vld_d;
  logic [MUL_LATENCY-1:0][1:0]  tag_idx_q, tag_idx_d;

  logic        tag_out_vld;
  logic [1:0]  tag_out_idx;
  logic        pipe_busy;
  logic [5:0]  pass_shift;
  logic [63:0] partial;
  logic [31:0] corr;
  logic [31:0] fix_hi;

  assign tag_out_vld = tag_vld_q[MUL_LATENCY-1];
  assign tag_out_idx = tag_idx_q[MUL_LATENCY-1];

  // Tag pipe shift: a pass enters whenever operands are on the cell inputs.
  always_comb begin
    tag_vld_d    = '0;
    tag_idx_d    = '0;
    tag_vld_d[0] = (state_q == StIssue);
    tag_idx_d[0] = k_q;
    for (int unsigned i = 1; i < MUL_LATENCY; i++) begin
      tag_vld_d[i] = tag_vld_q[i-1];
      tag_idx_d[i] = tag_idx_q[i-1];
    end
  end

  // Busy while any pass is still inside the cell other than the one emerging now.
  always_comb begin
    pipe_busy = 1'b0;
    for (int unsigned i = 0; i + 1 < MUL_LATENCY; i++) begin
      pipe_busy = pipe_busy | tag_vld_q[i];
    end
  end

  // Weight of the emerging partial product: LL=0, LH/HL=16, HH=32.
  always_comb begin
    pass_shift = 6'd0;
    case (tag_out_idx)
      2'd1, 2'd2: pass_shift = 6'd16;
      2'd3:       pass_shift = 6'd32;
      default:    pass_shift = 6'd0;
    endcase
    partial = {32'h0, mul_result} << pass_shift;
  end

  // Signed correction of the unsigned high word.
  always_comb begin
    corr = 32'h0;
    if (((op_q == OpMulxsu) || (op_q == OpMulxss)) && a_q[31]) begin
      corr = corr + b_q;
    end
    if ((op_q == OpMulxss) && b_q[31]) begin
      corr = corr + a_q;
    end
    fix_hi = acc_q[63:32] - corr;
  end

  // Next-state, operand latch, accumulate and response logic.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    a_d        = a_q;
    b_d        = b_q;
    k_d        = k_q;
    acc_d      = acc_q;
    rsp_data_d = rsp_data_q;

    if (tag_out_vld) begin
      if (op_q == OpMul) begin
        rsp_data_d = mul_result;
      end else begin
        acc_d = acc_q + partial;
      end
    end

    case (state_q)
      StIdle: begin
        if (req_valid) begin
          state_d = StIssue;
          op_d    = req_op;
          a_d     = req_a;
          b_d     = req_b;
          k_d     = 2'd0;
          acc_d   = 64'h0;
        end
      end
      StIssue: begin
        if ((op_q == OpMul) || (k_q == 2'd3)) begin
          state_d = StDrain;
        end else begin
          k_d = k_q + 2'd1;
        end
      end
      StDrain: begin
        if (!pipe_busy) begin
          state_d = (op_q == OpMul) ? StResp : StFix;
        end
      end
      StFix: begin
        rsp_data_d = fix_hi;
        state_d    = StResp;
      end
      StResp: begin
        if (rsp_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Cell operands are registered, so select them from the upcoming state and pass index.
  always_comb begin
    src1_d = 32'h0;
    src2_d = 32'h0;
    if (state_d == StIssue) begin
      if (op_d == OpMul) begin
        src1_d = a_d;
        src2_d = b_d;
      end else begin
        src1_d = {16'h0, k_d[1] ? a_d[31:16] : a_d[15:0]};
        src2_d = {16'h0, k_d[0] ? b_d[31:16] : b_d[15:0]};
      end
    end
  end

  // State registers with synchronous active-low reset; reset drops any in-flight op.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      op_q       <= 2'b00;
      a_q        <= 32'h0;
      b_q        <= 32'h0;
      k_q        <= 2'd0;
      acc_q      <= 64'h0;
      rsp_data_q <= 32'h0;
      src1_q     <= 32'h0;
      src2_q     <= 32'h0;
      tag_vld_q  <= '0;
      tag_idx_q  <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      a_q        <= a_d;
      b_q        <= b_d;
      k_q        <= k_d;
      acc_q      <= acc_d;
      rsp_data_q <= rsp_data_d;
      src1_q     <= src1_d;
      src2_q     <= src2_d;
      tag_vld_q  <= tag_vld_d;
      tag_idx_q  <= tag_idx_d;
    end
  end

  assign req_ready = (state_q == StIdle) && reset_n;
  assign rsp_valid = (state_q == StResp);
  assign rsp_data  = rsp_data_q;
  assign mul_src1  = src1_q;
  assign mul_src2  = src2_q;

endmodule

// File: tb/tb_reloj_nios2_qsys_0_mulx_seq.sv
// Bench for the multiply sequencer: two instances (cell latency 1 and 2) driven in
// lockstep, each with its own delayed multiply-cell model, checked against a 64-bit
// arithmetic reference.
module tb_reloj_nios2_qsys_0_mulx_seq;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid;
  logic        rsp_ready;
  logic [1:0]  req_op;
  logic [31:0] req_a;
  logic [31:0] req_b;

  logic        req_ready [2];
  logic        rsp_valid [2];
  logic [31:0] rsp_data  [2];
  logic [31:0] src1      [2];
  logic [31:0] src2      [2];
  logic [31:0] mres0, mres1, mstg1;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // Multiply cell models: low 32 bits of the product, 1 and 2 register stages.
  always @(posedge clk) mres0 <= src1[0] * src2[0];
  always @(posedge clk) begin
    mstg1 <= src1[1] * src2[1];
    mres1 <= mstg1;
  end

  reloj_nios2_qsys_0_mulx_seq #(.MUL_LATENCY(1)) u_dut0 (
    .clk       (clk),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .req_ready (req_ready[0]),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid[0]),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data[0]),
    .mul_src1  (src1[0]),
    .mul_src2  (src2[0]),
    .mul_result(mres0)
  );

  reloj_nios2_qsys_0_mulx_seq #(.MUL_LATENCY(2)) u_dut1 (
    .clk       (clk),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .req_ready (req_ready[1]),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid[1]),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data[1]),
    .mul_src1  (src1[1]),
    .mul_src2  (src2[1]),
    .mul_result(mres1)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: full product of the (sign- or zero-) extended operands.
  function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    logic [63:0] xa, xb, p;
    xa = (op[1]) ? {{32{a[31]}}, a} : {32'h0, a};
    xb = (op == 2'b11) ? {{32{b[31]}}, b} : {32'h0, b};
    p  = xa * xb;
    return (op == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  // Drive one request; returns just after the accept edge (end of cycle 0).
  task automatic launch(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    for (int d = 0; d < 2; d++) check_eq("launch_ready", 64'(req_ready[d]), 64'd1);
    req_valid = 1'b1;
    req_op    = op;
    req_a     = a;
    req_b     = b;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  // Follow an accepted op from cycle 1: operand trace, latency and result of both DUTs.
  task automatic collect(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input bit rnd_ready);
    logic [63:0] pairs [4];
    int          npass;
    int          first [2];
    bit          done  [2];
    int          exp_lat;
    if (op == 2'b00) begin
      npass    = 1;
      pairs[0] = {a, b};
    end else begin
      npass = 4;
      pairs[0] = {16'h0, a[15:0],  16'h0, b[15:0]};
      pairs[1] = {16'h0, a[15:0],  16'h0, b[31:16]};
      pairs[2] = {16'h0, a[31:16], 16'h0, b[15:0]};
      pairs[3] = {16'h0, a[31:16], 16'h0, b[31:16]};
    end
    first[0] = -1; first[1] = -1;
    done[0]  = 1'b0; done[1] = 1'b0;
    for (int cyc = 1; cyc <= 40 && !(done[0] && done[1]); cyc++) begin
      @(negedge clk);
      rsp_ready = rnd_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
      for (int d = 0; d < 2; d++) begin
        if (cyc <= 8) begin
          if (cyc <= npass) check_eq("src_pass", {src1[d], src2[d]}, pairs[cyc-1]);
          else              check_eq("src_idle", {src1[d], src2[d]}, 64'h0);
        end
        if (!done[d] && rsp_valid[d]) begin
          if (first[d] < 0) first[d] = cyc;
          if (rsp_ready) begin
            check_eq("rsp_data", 64'(rsp_data[d]), 64'(exp));
            done[d] = 1'b1;
          end
        end
      end
    end
    for (int d = 0; d < 2; d++) begin
      exp_lat = ((op == 2'b00) ? 2 : 6) + d + 1;
      check_eq("rsp_latency", 64'(first[d]), 64'(exp_lat));
      check_eq("rsp_handshake_seen", 64'(done[d]), 64'd1);
    end
    @(negedge clk);
    rsp_ready = 1'b1;
    for (int d = 0; d < 2; d++) begin
      check_eq("post_rsp_valid", 64'(rsp_valid[d]), 64'd0);
      check_eq("post_rsp_ready", 64'(req_ready[d]), 64'd1);
    end
  endtask

  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input bit rnd_ready);
    launch(op, a, b);
    collect(op, a, b, exp, rnd_ready);
  endtask

  initial begin
    logic [1:0]  op;
    logic [31:0] a, b;
    logic [31:0] held;

    reset_n   = 1'b0;
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    req_op    = 2'b00;
    req_a     = 32'h0;
    req_b     = 32'h0;

    // Reset values.
    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check_eq("rst_req_ready", 64'(req_ready[d]), 64'd0);
      check_eq("rst_rsp_valid", 64'(rsp_valid[d]), 64'd0);
      check_eq("rst_rsp_data",  64'(rsp_data[d]),  64'd0);
      check_eq("rst_src",       {src1[d], src2[d]}, 64'h0);
    end
    reset_n = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) check_eq("rel_req_ready", 64'(req_ready[d]), 64'd1);
    @(negedge clk);

    // Directed cases.
    run_op(2'b00, 32'h0001_0003, 32'h0002_0005, 32'h000B_000F, 1'b0);
    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0);
    run_op(2'b11, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 1'b0);
    run_op(2'b10, 32'h8000_0000, 32'h8000_0000, 32'hC000_0000, 1'b0);
    run_op(2'b11, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0);
    run_op(2'b01, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 1'b0);
    run_op(2'b00, 32'h0000_0007, 32'h0000_0006, 32'h0000_002A, 1'b0);

    // Backpressure with a request pending throughout.
    rsp_ready = 1'b0;
    req_valid = 1'b1;
    req_op    = 2'b11;
    req_a     = 32'h8000_0000;
    req_b     = 32'h8000_0000;
    @(posedge clk);
    #1;
    req_op = 2'b01;
    req_a  = 32'h0001_0000;
    req_b  = 32'h0001_0000;
    for (int i = 0; i < 40 && !(rsp_valid[0] && rsp_valid[1]); i++) @(negedge clk);
    check_eq("bp_wait", {63'h0, rsp_valid[0] && rsp_valid[1]}, 64'd1);
    for (int h = 0; h < 5; h++) begin
      for (int d = 0; d < 2; d++) begin
        check_eq("bp_rsp_valid", 64'(rsp_valid[d]), 64'd1);
        check_eq("bp_rsp_data",  64'(rsp_data[d]),  64'h4000_0000);
        check_eq("bp_req_ready", 64'(req_ready[d]), 64'd0);
      end
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check_eq("bp_drop_valid", 64'(rsp_valid[d]), 64'd0);
      check_eq("bp_next_ready", 64'(req_ready[d]), 64'd1);
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    collect(2'b01, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 1'b0);

    // Reset in cycle 3 of a MULXUU.
    launch(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    repeat (3) @(negedge clk);
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      check_eq("mid_rst_valid", 64'(rsp_valid[d]), 64'd0);
      check_eq("mid_rst_src",   {src1[d], src2[d]}, 64'h0);
      check_eq("mid_rst_ready", 64'(req_ready[d]), 64'd0);
    end
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) check_eq("mid_rel_ready", 64'(req_ready[d]), 64'd1);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) check_eq("no_stale_rsp", 64'(rsp_valid[d]), 64'd0);
    end
    run_op(2'b01, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 1'b0);

    // Randomized operations with random consumer stalls.
    for (int n = 0; n < 40; n++) begin
      op = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 3))
        0:       a = 32'h8000_0000;
        1:       a = 32'hFFFF_FFFF;
        default: a = $urandom;
      endcase
      case ($urandom_range(0, 3))
        0:       b = 32'h0000_0000;
        1:       b = 32'h8000_0001;
        default: b = $urandom;
      endcase
      held = model(op, a, b);
      run_op(op, a, b, held, 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
